// File: rtl/array3_packer.sv
// Packs a valid/ready stream of WIDTH-bit elements into DEPTH-element words.
// The assembly buffer and the output holding register form a double buffer.
module array3_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             CLEAR,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O [DEPTH-1:0],
    output logic             O_valid,
    input  logic             O_ready
);
    localparam int unsigned CW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q [DEPTH-2:0];
    logic [WIDTH-1:0] asm_d [DEPTH-2:0];
    logic [WIDTH-1:0] o_q   [DEPTH-1:0];
    logic [WIDTH-1:0] o_d   [DEPTH-1:0];
    logic             o_valid_q, o_valid_d;

    logic last_c, in_fire_c, out_fire_c;

    assign last_c     = (cnt_q == LAST);
    // Holding register is only blocked when the final element would need it and it cannot drain.
    assign I_ready    = !CLEAR && !(last_c && o_valid_q && !O_ready);
    assign in_fire_c  = I_valid && I_ready;
    assign out_fire_c = o_valid_q && O_ready;

    assign O       = o_q;
    assign O_valid = o_valid_q;

    // Next-state: element capture, word completion, drain and clear.
    always_comb begin
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;

        if (out_fire_c) begin
            o_valid_d = 1'b0;
        end

        if (CLEAR) begin
            cnt_d = '0;
        end else if (in_fire_c) begin
            if (last_c) begin
                for (int unsigned k = 0; k < DEPTH - 1; k++) begin
                    o_d[k] = asm_q[k];
                end
                o_d[DEPTH-1] = I;
                o_valid_d    = 1'b1;
                cnt_d        = '0;
            end else begin
                for (int unsigned k = 0; k < DEPTH - 1; k++) begin
                    if (cnt_q == CW'(k)) begin
                        asm_d[k] = I;
                    end
                end
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with asynchronous clear of everything.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
            for (int unsigned k = 0; k < DEPTH - 1; k++) begin
                asm_q[k] <= '0;
            end
            for (int unsigned k = 0; k < DEPTH; k++) begin
                o_q[k] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            asm_q     <= asm_d;
            o_q       <= o_d;
        end
    end

endmodule

// File: doc/array3_packer.md
# array3_packer

Upstream feeder for the nested-array register stage. Collects a stream of `WIDTH`-bit elements over a valid/ready handshake and assembles them into a `DEPTH`-element array word. The first element accepted lands in `O[0]`. The block presents each completed word on a registered, double-buffered output with its own valid/ready handshake. One element is accepted per cycle, and assembly of the next word continues while the previous word is stalled at the output.

## Interface
Parameters:
- `WIDTH`, default 8: bits per array element.
- `DEPTH`, default 3: elements per output word; legal range ≥ 2.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `ASYNCRESETN`  in  1  reset; asynchronous, active-low.
- `CLEAR`  in  1  synchronous discard of the partially assembled word.
- `I`  in  `WIDTH`  input element.
- `I_valid`  in  1  `I` is valid.
- `I_ready`  out  1  the block accepts `I` this cycle.
- `O`  out  `[WIDTH-1:0] x [DEPTH-1:0]` (unpacked array)  assembled word.
- `O_valid`  out  1  `O` holds a complete word.
- `O_ready`  in  1  the consumer takes `O` this cycle.

## Operation
State:
- Element counter `cnt`, range 0..`DEPTH-1`.
- Assembly buffer `asm[0..DEPTH-2]`.
- Output holding register `O` with flag `O_valid`.

Handshake events:
- Input fire = `I_valid && I_ready`.
- Output fire = `O_valid && O_ready`.

Ready rule:
- `I_ready = !CLEAR && !(cnt == DEPTH-1 && O_valid && !O_ready)`.
- `I_ready` depends combinationally on `O_ready`.
- `I_ready` has no dependency on `I_valid`.

Input fire with `cnt < DEPTH-1`:
- `asm[cnt] <= I`.
- `cnt <= cnt+1`.

Input fire with `cnt == DEPTH-1` (word completion):
- `O[k] <= asm[k]` for k < `DEPTH-1`.
- `O[DEPTH-1] <= I`.
- `O_valid <= 1`.
- `cnt <= 0`.

Output fire without completion in the same cycle:
- `O_valid <= 0`.
- `O` holds its value; the content is don't-care but must not change.

Output fire and completion in the same cycle:
- `O` reloads with the new word.
- `O_valid` stays 1; no bubble.

`CLEAR`:
- `cnt <= 0`; the `asm` contents become don't-care.
- `I_ready` is 0 in the same cycle, so no element is accepted.
- `O`/`O_valid` are unaffected; a pending word still drains normally.

`ASYNCRESETN` low, at any time, including mid-word or while a word is pending:
- Immediately forces `cnt=0`, `O_valid=0`, all `O` elements to 0, and all `asm` elements to 0.
- A partial or pending word is lost.

Element ordering: with `WIDTH=8`, `DEPTH=3`, the input sequence 0xDE, 0xAD, 0xBE yields `O[0]=8'hde`, `O[1]=8'had`, `O[2]=8'hbe`. The flat concatenation `{O[2],O[1],O[0]}` is `24'hbeadde`.

## Timing
Latency:
- `O_valid` rises on the edge that accepts the last element.
- It is visible in the cycle after that element is presented.

Throughput:
- One word per `DEPTH` cycles when `I_valid` and `O_ready` are held at 1.
- `I_ready` stays at 1 continuously in that case.

Back-pressure:
- With `O_valid=1` and `O_ready=0`, the block accepts at most `DEPTH-1` further elements.
- `I_ready` then drops, while `cnt == DEPTH-1`.
- `I_ready` returns in the same cycle `O_ready` rises, because that cycle's output fire frees the holding register.

Output stability: `O` must not change while `O_valid=1 && O_ready=0`.

Outputs after reset deasserts: `I_ready=1`, `O_valid=0`, `O=0`. The first accept can occur on the first rising edge after deassertion.

## Test plan
- Basic word (`O_ready`=1): feed 0xDE, 0xAD, 0xBE on consecutive cycles. Required: `O_valid`=1 for exactly one cycle, with `O[0..2]` = 0xDE/0xAD/0xBE.
- Streaming: feed 9 elements 0x01..0x09 back-to-back. Required: 3 words (01,02,03), (04,05,06), (07,08,09) on cycles 3/6/9, `I_ready` never low.
- Back-pressure: hold `O_ready`=0 after the first word completes and offer 0x11, 0x22, 0x33. Required: 0x11 and 0x22 are accepted, then `I_ready`=0 with 0x33 held and `O` stable at the first word. Raising `O_ready` must accept 0x33 that same cycle; the next cycle shows (11,22,33) with `O_valid` still 1.
- Clear mid-word: accept 0xAA, 0xBB, then pulse `CLEAR` while offering 0xCC. Required: 0xCC is not accepted. Then 0x01, 0x02, 0x03 must produce exactly (01,02,03).
- Async reset while a word is pending: assert `ASYNCRESETN`=0 between edges while `O_valid`=1. Required: `O_valid`=0 and `O`=0 immediately, without waiting for an edge. After release, 3 elements produce a clean word.
- Parameter sweep: `DEPTH`=2 and `WIDTH`=16 with 0x1234, 0xABCD. Required: `O[0]`=0x1234, `O[1]`=0xABCD. Back-pressure allows exactly 1 additional accept.
